dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/defs.sv | 16 +
 rtl/dmem_arb_pick.sv | 24 ++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/defs.sv
// Shared types and sizing for the data-memory arbiter.
package defs;

  typedef logic [31:0] data_t;
  typedef logic [3:0]  enable_t;

  localparam int      DMEM_SIZE = 4096;
  localparam enable_t WEN_WORD  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between core and debug requesters.
// prio_dbg=1 lets dbg win a conflict; it is tied low for fixed core priority.
module dmem_arb_pick (
  input  logic core_req,
  input  logic dbg_req,
  input  logic prio_dbg,
  input  logic enable,
  output logic core_gnt,
  output logic dbg_gnt
);

  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (enable) begin
      if (core_req && (!dbg_req || !prio_dbg)) begin
        core_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core / debug) arbiter in front of a single-ported DMEM.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed core priority.
import defs::*;

module dmem_arbiter #(
  parameter int MEM_SIZE = DMEM_SIZE
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    core_req_i,
  input  logic    core_we_i,
  input  data_t   core_addr_i,
  input  data_t   core_wdata_i,
  output logic    core_gnt_o,
  output logic    core_rvalid_o,
  output logic    core_err_o,
  output data_t   core_rdata_o,
  input  logic    dbg_req_i,
  input  logic    dbg_we_i,
  input  data_t   dbg_addr_i,
  input  data_t   dbg_wdata_i,
  output logic    dbg_gnt_o,
  output logic    dbg_rvalid_o,
  output logic    dbg_err_o,
  output data_t   dbg_rdata_o,
  output logic    mem_ren_o,
  output enable_t mem_wen_o,
  output data_t   mem_addr_o,
  output data_t   mem_wdata_o,
  input  data_t   mem_rdata_i,
  output logic    core_stall_o
);

  arb_state_t state_q, state_d;
  logic  lat_dbg, lat_we;
  data_t lat_addr, lat_wdata;
  logic  prio_dbg, accept, in_range;
  data_t resp_data;

  dmem_arb_pick u_pick (
    .core_req (core_req_i),
    .dbg_req  (dbg_req_i),
    .prio_dbg (prio_dbg),
    .enable   (state_q == IDLE || state_q == RESP),
    .core_gnt (core_gnt_o),
    .dbg_gnt  (dbg_gnt_o)
  );

  assign accept       = core_gnt_o | dbg_gnt_o;
  assign in_range     = lat_addr < data_t'(MEM_SIZE);
  assign resp_data    = (!lat_we && in_range) ? mem_rdata_i : '0;
  assign core_stall_o = core_req_i & ~core_rvalid_o;

`ifdef DMEM_ARB_RR_EN
  // After serving core, the next conflict goes to dbg, and vice versa.
  logic prio_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (accept) begin
      prio_q <= core_gnt_o;
    end
  end
  assign prio_dbg = prio_q;
`else
  assign prio_dbg = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_dbg   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lat_dbg   <= dbg_gnt_o;
        lat_we    <= dbg_gnt_o ? dbg_we_i    : core_we_i;
        lat_addr  <= dbg_gnt_o ? dbg_addr_i  : core_addr_i;
        lat_wdata <= dbg_gnt_o ? dbg_wdata_i : core_wdata_i;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_ren_o     = 1'b0;
    mem_wen_o     = '0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    core_rvalid_o = 1'b0;
    dbg_rvalid_o  = 1'b0;
    core_err_o    = 1'b0;
    dbg_err_o     = 1'b0;
    core_rdata_o  = '0;
    dbg_rdata_o   = '0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ACCESS;
      end
      ACCESS: begin
        mem_addr_o  = lat_addr;
        mem_wdata_o = lat_wdata;
        // Out-of-range accesses never touch the memory.
        if (in_range) begin
          mem_ren_o = !lat_we;
          mem_wen_o = lat_we ? WEN_WORD : '0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (lat_dbg) begin
          dbg_rvalid_o = 1'b1;
          dbg_err_o    = !in_range;
          dbg_rdata_o  = resp_data;
        end else begin
          core_rvalid_o = 1'b1;
          core_err_o    = !in_range;
          core_rdata_o  = resp_data;
        end
        state_d = accept ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_dmem_arbiter;
  import defs::*;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    core_req, core_we, core_gnt, core_rvalid, core_err, core_stall;
  data_t   core_addr, core_wdata, core_rdata;
  logic    dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
  data_t   dbg_addr, dbg_wdata, dbg_rdata;
  logic    mem_ren;
  enable_t mem_wen;
  data_t   mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_err_o(core_err), .core_rdata_o(core_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_err_o(dbg_err), .dbg_rdata_o(dbg_rdata),
    .mem_ren_o(mem_ren), .mem_wen_o(mem_wen), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .core_stall_o(core_stall)
  );

  // Synchronous-read memory; non-read cycles return junk so stale data is caught.
  logic [31:0] mem_arr [0:1023];
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem_arr[mem_addr[11:2]];
    else         mem_rdata <= 32'hBAD0BAD0;
    for (int b = 0; b < 4; b++)
      if (mem_wen[b]) mem_arr[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  typedef struct {
    bit    port;
    bit    we;
    data_t addr;
    data_t wdata;
    data_t exp_rdata;
    bit    exp_err;
  } vec_t;

  typedef struct {
    bit    port;
    data_t rdata;
    bit    err;
    int    cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input bit port, input data_t rdata, input bit err);
    exp_t e;
    e.port = port; e.rdata = rdata; e.err = err; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Response monitor: every rvalid must match the oldest outstanding grant, 2 cycles later.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (core_rvalid || dbg_rvalid) begin
        chk("rvalid_onehot", {31'd0, core_rvalid & dbg_rvalid}, 0);
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_port", {31'd0, dbg_rvalid}, {31'd0, mon_e.port});
          chk("rsp_rdata", mon_e.port ? dbg_rdata : core_rdata, mon_e.rdata);
          chk("rsp_err", {31'd0, mon_e.port ? dbg_err : core_err}, {31'd0, mon_e.err});
          chk("rsp_latency", cyc - mon_e.cyc, 2);
        end
      end else begin
        chk("err_without_rvalid", {30'd0, core_err, dbg_err}, 0);
      end
    end
  end

  task automatic chk_quiet(input string tag);
    chk(tag, {22'd0, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, core_err, dbg_err, mem_ren, mem_wen}, 0);
    chk({tag, "_rdata"}, core_rdata | dbg_rdata, 0);
    chk({tag, "_mem_bus"}, mem_addr | mem_wdata, 0);
  endtask

  // Caller is at a negedge; returns at the negedge of the ACCESS cycle.
  task automatic issue(input vec_t v);
    int n = 0;
    if (v.port) begin
      dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
    end else begin
      core_req = 1'b1; core_we = v.we; core_addr = v.addr; core_wdata = v.wdata;
    end
    #1;
    while (!(v.port ? dbg_gnt : core_gnt) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      chk("grant_timeout", 1, 0);
      core_req = 1'b0; dbg_req = 1'b0;
      return;
    end
    chk("other_gnt_low", {31'd0, v.port ? core_gnt : dbg_gnt}, 0);
    push_exp(v.port, v.exp_rdata, v.exp_err);
    @(posedge clk); #1;
    core_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);
    chk("access_ren", {31'd0, mem_ren}, {31'd0, !v.we && !v.exp_err});
    chk("access_wen", {28'd0, mem_wen}, (v.we && !v.exp_err) ? 32'hF : 32'h0);
    if (!v.exp_err) chk("access_addr", mem_addr, v.addr);
    if (v.we && !v.exp_err) chk("access_wdata", mem_wdata, v.wdata);
  endtask

  // Both ports request reads; each granted port drops req once its count is used up.
  task automatic contend(input int core_n, input int dbg_n, input data_t core_a, input data_t core_e,
                         input data_t dbg_a, input data_t dbg_e, output logic [3:0] order, output int gap);
    int n = 0;
    int k = 0;
    int first_cyc = 0;
    order = '0; gap = 0;
    core_we = 1'b0; core_addr = core_a; core_req = (core_n > 0);
    dbg_we  = 1'b0; dbg_addr  = dbg_a;  dbg_req  = (dbg_n > 0);
    #1;
    while ((core_n > 0 || dbg_n > 0) && n < 40) begin
      if (core_gnt || dbg_gnt) begin
        chk("gnt_onehot", {31'd0, core_gnt & dbg_gnt}, 0);
        push_exp(dbg_gnt, dbg_gnt ? dbg_e : core_e, 1'b0);
        if (k < 4) order[k] = dbg_gnt;
        if (k == 0) first_cyc = cyc;
        else if (k == 1) gap = cyc - first_cyc;
        k++;
        if (core_gnt) core_n--; else dbg_n--;
      end
      @(posedge clk); #1;
      if (core_n == 0) core_req = 1'b0;
      if (dbg_n == 0)  dbg_req  = 1'b0;
      @(negedge clk); #1; n++;
    end
    if (n >= 40) chk("contend_timeout", 1, 0);
    core_req = 1'b0; dbg_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vec_t vecs[14];
    data_t b2b[3];
    int gcyc[3];
    logic [3:0] order;
    int gap;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'h20,       32'h12345678, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h20,       32'h0,        32'h12345678, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h1000,     32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'hFFC,      32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'hFFC,      32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h1000,     32'hCAFEF00D, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h0,        32'h11111111, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 1'b1, 32'h4,        32'h22222222, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h8,        32'h33333333, 32'h0,        1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h0,        32'h0,        32'h11111111, 1'b0};
    b2b[0] = 32'h11111111; b2b[1] = 32'h22222222; b2b[2] = 32'h33333333;

    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk_quiet("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("after_reset");
    chk("after_reset_stall", {31'd0, core_stall}, 0);

    foreach (vecs[i]) issue(vecs[i]);
    drain();

    // Conflict from IDLE right after reset: core first, dbg in core's RESP cycle.
    reset_dut();
    contend(1, 1, 32'h10, 32'hDEADBEEF, 32'h20, 32'h12345678, order, gap);
    chk("conflict1_order", {28'd0, order}, 32'b0010);
    chk("conflict1_gap", gap, 2);
    drain();

    // Second conflict with core re-requesting: only round-robin hands dbg the RESP slot.
    contend(2, 1, 32'h10, 32'hDEADBEEF, 32'h20, 32'h12345678, order, gap);
`ifdef DMEM_ARB_RR_EN
    chk("conflict2_order", {28'd0, order}, 32'b0010);
`else
    chk("conflict2_order", {28'd0, order}, 32'b0100);
`endif
    drain();

    // Back-to-back core reads with req held high.
    core_we = 1'b0; core_addr = 32'h0; core_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      #1;
      while (!core_gnt && n < 20) begin
        chk("b2b_stall", {31'd0, core_stall}, {31'd0, !core_rvalid});
        @(negedge clk); #1; n++;
      end
      chk("b2b_stall", {31'd0, core_stall}, {31'd0, !core_rvalid});
      if (n >= 20) chk("b2b_grant_timeout", 1, 0);
      push_exp(1'b0, b2b[i], 1'b0);
      gcyc[i] = cyc;
      @(posedge clk); #1;
      if (i < 2) core_addr = data_t'((i + 1) * 4);
      else       core_req  = 1'b0;
      @(negedge clk);
    end
    chk("b2b_gap01", gcyc[1] - gcyc[0], 2);
    chk("b2b_gap12", gcyc[2] - gcyc[1], 2);
    drain();

    // Reset while a core read sits in ACCESS: transaction is dropped silently.
    core_we = 1'b0; core_addr = 32'h10; core_req = 1'b1;
    #1;
    chk("abort_gnt", {31'd0, core_gnt}, 1);
    @(posedge clk); #1;
    core_req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("abort_access_ren", {31'd0, mem_ren}, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("abort_next");
    repeat (4) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
